// File: rtl/fft_blk_src_pkg.sv
// Types and helpers shared by the FFT block source and its rounding rail.
`ifndef FIXED_POINT_MACROS_SVH
`include "fixed_point_macros.svh"
`endif

package fft_blk_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int unsigned LDN_WIDTH = 4;
    localparam int unsigned CNT_WIDTH = `LDN_MAX;

    function automatic logic ldn_legal(input logic [LDN_WIDTH-1:0] ldn);
        return (ldn >= LDN_WIDTH'(`LDN_MIN)) && (ldn <= LDN_WIDTH'(`LDN_MAX));
    endfunction

    // Index of the last sample of a 2^ldn block.
    function automatic logic [CNT_WIDTH-1:0] last_idx(input logic [LDN_WIDTH-1:0] ldn);
        logic [CNT_WIDTH:0] n;
        n = (CNT_WIDTH+1)'(1) << ldn;
        return CNT_WIDTH'(n - (CNT_WIDTH+1)'(1));
    endfunction

endpackage

// File: rtl/fft_src_rnd.sv
// Combinational round of one rail from IN_WIDTH down to MAN_WIDTH.
// FFT_SRC_SAT_EN clamps positive overflow; otherwise the result wraps.
`ifndef FIXED_POINT_MACROS_SVH
`include "fixed_point_macros.svh"
`endif

module fft_src_rnd
    import fft_blk_src_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]   din_i,
    output logic signed [`MAN_WIDTH-1:0] dout_c_o
);

    localparam int unsigned MAN_W = `MAN_WIDTH;
    localparam int unsigned D     = IN_WIDTH - MAN_W;

    if (D == 0) begin : g_pass
        assign dout_c_o = din_i;
    end else begin : g_rnd
`ifdef FFT_SRC_SAT_EN
        localparam logic signed [MAN_W:0] MAX_POS = (MAN_W+1)'((1 << (MAN_W - 1)) - 1);
        logic signed [MAN_W:0] rnd_c;
        assign rnd_c    = (MAN_W+1)'(`SYMRND(din_i, D));
        assign dout_c_o = (rnd_c > MAX_POS) ? MAX_POS[MAN_W-1:0] : rnd_c[MAN_W-1:0];
`else
        assign dout_c_o = MAN_W'(`SYMRND(din_i, D));
`endif
    end

endmodule

// File: rtl/fixed_point_macros.svh
// Shared fixed-point widths, ldn legality bounds and symmetric-rounding helper.
`ifndef FIXED_POINT_MACROS_SVH
`define FIXED_POINT_MACROS_SVH

`define MAN_WIDTH 14
`define EXP_WIDTH 5
`define LDN_MIN   3
`define LDN_MAX   11

// Round x right by d bits, half away from zero; result is 32-bit signed (d > 0).
`define SYMRND(x, d) ((32'(x) + ((32'(x) < 0) ? ((32'sd1 <<< ((d) - 1)) - 32'sd1) : (32'sd1 <<< ((d) - 1)))) >>> (d))

`endif

// File: rtl/fft_blk_src.sv
// FFT block source: frames 2^ldn input samples into blocks with sync pulses and
// converts them to mantissa/exponent. Optional macro: FFT_SRC_SAT_EN.
`ifndef FIXED_POINT_MACROS_SVH
`include "fixed_point_macros.svh"
`endif

module fft_blk_src
    import fft_blk_src_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter bit          ERR_STICKY = 1'b1
) (
    input  logic                         clk_sys,
    input  logic                         rst_sys_n,
    input  logic                         start_i,
    input  logic [3:0]                   ldn_rg_i,
    input  logic                         in_val_i,
    input  logic signed [IN_WIDTH-1:0]   in_real_i,
    input  logic signed [IN_WIDTH-1:0]   in_imag_i,
    input  logic                         clr_err_i,
    output logic                         ready_o,
    output logic                         block_sync_o,
    output logic                         stage_sync_o,
    output logic                         data_val_o,
    output logic signed [`MAN_WIDTH-1:0] data_real_o,
    output logic signed [`MAN_WIDTH-1:0] data_imag_o,
    output logic signed [`EXP_WIDTH-1:0] data_exp_o,
    output logic [3:0]                   ldn_rg_o,
    output logic                         err_o
);

    localparam int unsigned               D     = IN_WIDTH - `MAN_WIDTH;
    localparam logic signed [`EXP_WIDTH-1:0] EXP_D = `EXP_WIDTH'(D);

    state_e                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [LDN_WIDTH-1:0]          ldn_q, ldn_d;
    logic                          ready_q, ready_d;
    logic                          sync_q, sync_d;
    logic                          val_q, val_d;
    logic                          err_q, err_d;
    logic signed [`MAN_WIDTH-1:0]  re_q, re_d, im_q, im_d;
    logic signed [`EXP_WIDTH-1:0]  exp_q, exp_d;
    logic signed [`MAN_WIDTH-1:0]  rnd_re_c, rnd_im_c;
    logic                          accept_c, last_c, err_ev_c;

    fft_src_rnd #(.IN_WIDTH(IN_WIDTH)) u_rnd_re (.din_i(in_real_i), .dout_c_o(rnd_re_c));
    fft_src_rnd #(.IN_WIDTH(IN_WIDTH)) u_rnd_im (.din_i(in_imag_i), .dout_c_o(rnd_im_c));

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ldn_d    = ldn_q;
        err_ev_c = 1'b0;
        accept_c = (state_q == ST_RUN) && in_val_i;
        last_c   = accept_c && (cnt_q == last_idx(ldn_q));

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (ldn_legal(ldn_rg_i)) begin
                        ldn_d   = ldn_rg_i;
                        cnt_d   = '0;
                        state_d = ST_SYNC;
                    end else begin
                        err_ev_c = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                state_d = ST_RUN;
                if (start_i) err_ev_c = 1'b1;
            end
            ST_RUN: begin
                if (accept_c) cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_c) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (start_i) begin
                        if (ldn_legal(ldn_rg_i)) begin
                            ldn_d   = ldn_rg_i;
                            state_d = ST_SYNC;
                        end else begin
                            err_ev_c = 1'b1;
                        end
                    end
                end else if (start_i) begin
                    err_ev_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Samples offered while not ready are dropped.
        if (in_val_i && (state_q != ST_RUN)) err_ev_c = 1'b1;

        ready_d = (state_d == ST_RUN);
        sync_d  = (state_q == ST_SYNC);
        val_d   = accept_c;
        re_d    = accept_c ? rnd_re_c : '0;
        im_d    = accept_c ? rnd_im_c : '0;
        exp_d   = accept_c ? EXP_D : '0;

        if (clr_err_i)     err_d = 1'b0;
        else if (err_ev_c) err_d = 1'b1;
        else               err_d = ERR_STICKY ? err_q : 1'b0;
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ldn_q   <= '0;
            ready_q <= 1'b0;
            sync_q  <= 1'b0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldn_q   <= ldn_d;
            ready_q <= ready_d;
            sync_q  <= sync_d;
            val_q   <= val_d;
            err_q   <= err_d;
            re_q    <= re_d;
            im_q    <= im_d;
            exp_q   <= exp_d;
        end
    end

    assign ready_o      = ready_q;
    assign block_sync_o = sync_q;
    assign stage_sync_o = sync_q;
    assign data_val_o   = val_q;
    assign data_real_o  = re_q;
    assign data_imag_o  = im_q;
    assign data_exp_o   = exp_q;
    assign ldn_rg_o     = ldn_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fft_blk_src.sv
// Bench for fft_blk_src: block-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`ifndef FIXED_POINT_MACROS_SVH
`include "fixed_point_macros.svh"
`endif

module tb_fft_blk_src;

    localparam int IN_W   = 16;
    localparam int MAN_W  = `MAN_WIDTH;
    localparam int D      = IN_W - MAN_W;
    localparam int MAXP   = (1 << (MAN_W - 1)) - 1;
    localparam bit STICKY = 1'b1;
`ifdef FFT_SRC_SAT_EN
    localparam int MAX_IN_OUT = 8191;
`else
    localparam int MAX_IN_OUT = -8192;
`endif

    logic                         clk_sys = 1'b0;
    logic                         rst_sys_n;
    logic                         start_i, in_val_i, clr_err_i;
    logic [3:0]                   ldn_rg_i;
    logic signed [IN_W-1:0]       in_real_i, in_imag_i;
    logic                         ready_o, block_sync_o, stage_sync_o, data_val_o, err_o;
    logic signed [MAN_W-1:0]      data_real_o, data_imag_o;
    logic signed [`EXP_WIDTH-1:0] data_exp_o;
    logic [3:0]                   ldn_rg_o;

    fft_blk_src #(.IN_WIDTH(IN_W), .ERR_STICKY(STICKY)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_i(start_i), .ldn_rg_i(ldn_rg_i),
        .in_val_i(in_val_i), .in_real_i(in_real_i), .in_imag_i(in_imag_i), .clr_err_i(clr_err_i),
        .ready_o(ready_o), .block_sync_o(block_sync_o), .stage_sync_o(stage_sync_o),
        .data_val_o(data_val_o), .data_real_o(data_real_o), .data_imag_o(data_imag_o),
        .data_exp_o(data_exp_o), .ldn_rg_o(ldn_rg_o), .err_o(err_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    // Reference rounding: magnitude rounded half-up, sign restored, then clamp or wrap.
    function automatic int mrnd(input int x);
        int mag, r;
        if (D == 0) return x;
        mag = (x < 0) ? -x : x;
        r   = (mag + (1 << (D - 1))) / (1 << D);
        r   = (x < 0) ? -r : r;
`ifdef FFT_SRC_SAT_EN
        if (r > MAXP) r = MAXP;
`else
        if (r > MAXP) r = r - (1 << MAN_W);
`endif
        return r;
    endfunction

    function automatic bit legal(input int l);
        return (l >= 3) && (l <= 11);
    endfunction

    // Block-level model: open block with samples remaining, and a pending sync.
    bit       m_open = 0, m_wait = 0, m_ev = 0, m_was_open = 0;
    int       m_rem = 0;
    bit       e_ready = 0, e_sync = 0, e_val = 0, e_err = 0;
    int       e_re = 0, e_im = 0, e_exp = 0, e_ldn = 0;

    always @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            m_open = 0; m_wait = 0; m_rem = 0;
            e_ready = 0; e_sync = 0; e_val = 0; e_err = 0;
            e_re = 0; e_im = 0; e_exp = 0; e_ldn = 0;
        end else begin
            m_ev = 0; m_was_open = m_open;
            e_sync = 0; e_val = 0; e_re = 0; e_im = 0; e_exp = 0;
            if (m_was_open) begin
                if (in_val_i) begin
                    e_val = 1; e_re = mrnd(int'(in_real_i)); e_im = mrnd(int'(in_imag_i)); e_exp = D;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_open = 0;
                        if (start_i) begin
                            if (legal(int'(ldn_rg_i))) begin e_ldn = int'(ldn_rg_i); m_wait = 1; end
                            else m_ev = 1;
                        end
                    end else if (start_i) m_ev = 1;
                end else if (start_i) m_ev = 1;
            end else if (m_wait) begin
                m_wait = 0; m_open = 1; e_sync = 1; m_rem = 1 << e_ldn;
                if (start_i) m_ev = 1;
            end else if (start_i) begin
                if (legal(int'(ldn_rg_i))) begin e_ldn = int'(ldn_rg_i); m_wait = 1; end
                else m_ev = 1;
            end
            if (in_val_i && !m_was_open) m_ev = 1;
            if (clr_err_i) e_err = 0;
            else if (m_ev) e_err = 1;
            else if (!STICKY) e_err = 0;
            e_ready = m_open;
        end
    end

    int n_bsync = 0, n_ssync = 0, n_val = 0;
    always @(negedge clk_sys) begin
        if (block_sync_o) n_bsync++;
        if (stage_sync_o) n_ssync++;
        if (data_val_o)   n_val++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ready_o",      int'(ready_o),      int'(e_ready));
        chk("block_sync_o", int'(block_sync_o), int'(e_sync));
        chk("stage_sync_o", int'(stage_sync_o), int'(e_sync));
        chk("data_val_o",   int'(data_val_o),   int'(e_val));
        chk("data_real_o",  int'(data_real_o),  e_re);
        chk("data_imag_o",  int'(data_imag_o),  e_im);
        chk("data_exp_o",   int'(data_exp_o),   e_exp);
        chk("ldn_rg_o",     int'(ldn_rg_o),     e_ldn);
        chk("err_o",        int'(err_o),        int'(e_err));
    endtask

    task automatic drive(input bit st, input int ldn, input bit v, input int re, input int im, input bit clr);
        @(negedge clk_sys);
        start_i = st; ldn_rg_i = 4'(ldn); in_val_i = v;
        in_real_i = IN_W'(re); in_imag_i = IN_W'(im); clr_err_i = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int sb, ss, sv;
    int t4_re[8] = '{6, 32767, 5, 2, 10, 0, 1, -32768};
    int t4_im[8] = '{-6, -32768, -5, -2, -10, 7, -1, 32767};

    initial begin
        rst_sys_n = 1; start_i = 0; ldn_rg_i = 0; in_val_i = 0;
        in_real_i = 0; in_imag_i = 0; clr_err_i = 0;
        fork
            forever begin
                @(negedge clk_sys);
                compare();
            end
        join_none
        #1 rst_sys_n = 0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_ldn",   int'(ldn_rg_o), 0);
        chk("rst_err",   int'(err_o), 0);
        rst_sys_n = 1;

        // Basic ldn=3 block, samples 1..8.
        sb = n_bsync; ss = n_ssync; sv = n_val;
        drive(1, 3, 0, 0, 0, 0);
        idle();
        for (int k = 1; k <= 8; k++) drive(0, 3, 1, k, -k, 0);
        idle(); idle();
        chk("t1_bsync_cnt", n_bsync - sb, 1);
        chk("t1_ssync_cnt", n_ssync - ss, 1);
        chk("t1_val_cnt",   n_val - sv, 8);
        chk("t1_ready_end", int'(ready_o), 0);
        chk("t1_ldn",       int'(ldn_rg_o), 3);

        // Back-to-back ldn=4 blocks, restart on the last sample, gap in the second.
        sb = n_bsync; sv = n_val;
        drive(1, 4, 0, 0, 0, 0);
        idle();
        for (int k = 0; k < 15; k++) drive(0, 4, 1, 100 + k, -(100 + k), 0);
        drive(1, 4, 1, 115, -115, 0);
        idle();
        chk("t2_sync_ready",  int'(ready_o), 0);
        chk("t2_last_val",    int'(data_val_o), 1);
        for (int k = 0; k < 16; k++) begin
            drive(0, 4, 1, 200 + k, 3 * k, 0);
            if (k == 0) chk("t2_bsync2", int'(block_sync_o), 1);
            if (k == 7) idle();
        end
        idle(); idle();
        chk("t2_bsync_cnt", n_bsync - sb, 2);
        chk("t2_val_cnt",   n_val - sv, 32);
        chk("t2_err",       int'(err_o), 0);

        // Protocol errors and clear.
        sv = n_val;
        drive(0, 0, 1, 5, 5, 0);
        idle();
        chk("t3_err_idle_val", int'(err_o), 1);
        chk("t3_no_data",      n_val - sv, 0);
        drive(0, 0, 0, 0, 0, 1);
        idle();
        chk("t3_clr", int'(err_o), 0);
        sb = n_bsync; sv = n_val;
        drive(1, 3, 0, 0, 0, 0);
        idle();
        drive(0, 3, 1, 1, 1, 0);
        drive(1, 3, 1, 2, 2, 0);
        idle();
        chk("t3_err_run_start", int'(err_o), 1);
        for (int k = 3; k <= 8; k++) drive(0, 3, 1, k, k, 0);
        idle(); idle();
        chk("t3_one_block", n_bsync - sb, 1);
        chk("t3_val_cnt",   n_val - sv, 8);
        drive(0, 0, 0, 0, 0, 1);
        sv = n_val;
        drive(1, 12, 0, 0, 0, 0);
        idle();
        chk("t3_err_ldn12",   int'(err_o), 1);
        chk("t3_ldn12_ready", int'(ready_o), 0);
        chk("t3_ldn_kept",    int'(ldn_rg_o), 3);
        chk("t3_ldn12_nodat", n_val - sv, 0);
        drive(1, 12, 0, 0, 0, 1);
        idle();
        chk("t3_clr_priority", int'(err_o), 0);
        drive(1, 2, 0, 0, 0, 0);
        idle();
        chk("t3_err_ldn2", int'(err_o), 1);
        drive(0, 0, 0, 0, 0, 1);
        idle();
        chk("t3_clr2", int'(err_o), 0);

        // Rounding and overflow behaviour.
        drive(1, 3, 0, 0, 0, 0);
        idle();
        for (int k = 0; k < 8; k++) begin
            drive(0, 3, 1, t4_re[k], t4_im[k], 0);
            case (k)
                1: begin
                    chk("t4_re_p6",  int'(data_real_o), 2);
                    chk("t4_im_m6",  int'(data_imag_o), -2);
                    chk("t4_exp",    int'(data_exp_o), 2);
                end
                2: begin
                    chk("t4_re_max", int'(data_real_o), MAX_IN_OUT);
                    chk("t4_im_min", int'(data_imag_o), -8192);
                end
                3: chk("t4_re_5",  int'(data_real_o), 1);
                4: chk("t4_im_m2", int'(data_imag_o), -1);
                5: chk("t4_re_10", int'(data_real_o), 3);
                default: ;
            endcase
        end
        idle(); idle();

        // Asynchronous reset mid-block, then a clean block.
        drive(1, 3, 0, 0, 0, 0);
        idle();
        for (int k = 1; k <= 5; k++) drive(0, 3, 1, 40 * k, -40 * k, 0);
        @(negedge clk_sys);
        start_i = 0; in_val_i = 0;
        #2 rst_sys_n = 0;
        #1;
        chk("t5_rst_ready", int'(ready_o), 0);
        chk("t5_rst_val",   int'(data_val_o), 0);
        chk("t5_rst_re",    int'(data_real_o), 0);
        chk("t5_rst_ldn",   int'(ldn_rg_o), 0);
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1;
        sb = n_bsync; sv = n_val;
        idle(); idle(); idle();
        chk("t5_no_partial_sync", n_bsync - sb, 0);
        chk("t5_no_partial_val",  n_val - sv, 0);
        drive(1, 3, 0, 0, 0, 0);
        idle();
        for (int k = 1; k <= 8; k++) drive(0, 3, 1, -k * 7, k * 9, 0);
        idle(); idle();
        chk("t5_fresh_sync", n_bsync - sb, 1);
        chk("t5_fresh_val",  n_val - sv, 8);
        chk("t5_fresh_err",  int'(err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_blk_src.md
FFT_BLK_SRC -- requirements
Module: fft_blk_src

Interface
REQ-001 Parameter IN_WIDTH, default 16, input sample width in bits; must be at least `MAN_WIDTH.
REQ-002 Parameter ERR_STICKY, default 1; 1 = err_o held until clr_err_i, 0 = err_o is a one-cycle pulse.
REQ-003 Port clk_sys, input, 1, system clock; all logic SHALL be clocked on its rising edge (one clock).
REQ-004 Port rst_sys_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port start_i, input, 1, request to open a new block.
REQ-006 Port ldn_rg_i, input, 4, log2 of the block length; legal values 3..11.
REQ-007 Port in_val_i, input, 1, input sample valid.
REQ-008 Ports in_real_i and in_imag_i, input, signed IN_WIDTH each, input sample.
REQ-009 Port clr_err_i, input, 1, clears err_o.
REQ-010 Port ready_o, output, 1, block open and accepting samples.
REQ-011 Ports block_sync_o and stage_sync_o, output, 1 each, block-start pulse and stage-start pulse.
REQ-012 Port data_val_o, output, 1, output sample valid.
REQ-013 Ports data_real_o and data_imag_o, output, signed `MAN_WIDTH each, output mantissa.
REQ-014 Port data_exp_o, output, signed `EXP_WIDTH, output exponent.
REQ-015 Port ldn_rg_o, output, 4, latched ldn of the current block.
REQ-016 Port err_o, output, 1, protocol error flag.

Function
REQ-017 States SHALL be IDLE, SYNC and RUN; all outputs SHALL be registered.
REQ-018 IDLE: start_i with ldn_rg_i in 3..11 -> latch ldn into ldn_rg_o and go to SYNC.
REQ-019 IDLE: start_i with ldn_rg_i outside 3..11 -> stay in IDLE and flag an error.
REQ-020 SYNC lasts exactly one cycle; block_sync_o and stage_sync_o SHALL be 1 in the cycle after SYNC is entered; then go to RUN.
REQ-021 ready_o SHALL be 1 only in RUN.
REQ-022 RUN: each in_val_i=1 SHALL give data_val_o=1 exactly one cycle later carrying that sample; the sample counter increments.
REQ-023 Each block SHALL accept exactly N = 2^ldn samples; gaps (in_val_i=0) are allowed and emit data_val_o=0 with data outputs 0.
REQ-024 On accepting sample N-1: start_i=0 -> IDLE; start_i=1 with legal ldn -> SYNC directly, giving back-to-back blocks with no idle cycle.
REQ-025 start_i during SYNC, or during RUN other than on the sample N-1 cycle, SHALL be ignored and flag an error.
REQ-026 in_val_i while ready_o=0 SHALL drop the sample and flag an error.
REQ-027 Conversion with D = IN_WIDTH - `MAN_WIDTH: D=0 -> pass through unchanged, data_exp_o=0.
REQ-028 Conversion with D>0 -> symmetric round (half away from zero) right by D bits, data_exp_o=D.
REQ-029 clr_err_i SHALL take priority over a simultaneous error event in the same cycle.

Reset
REQ-030 rst_sys_n low SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (ldn_rg_o=0, err_o=0).
REQ-031 Reset mid-block SHALL abandon the block; no partial block_sync_o or data_val_o after release.

Configuration
REQ-032 FFT_SRC_SAT_EN defined: a rounding result exceeding +(2^(`MAN_WIDTH-1))-1 SHALL clamp to that value.
REQ-033 FFT_SRC_SAT_EN undefined: the rounding result SHALL wrap (truncate to `MAN_WIDTH bits); no clamp logic is present.

Structure
REQ-034 `MAN_WIDTH, `EXP_WIDTH, `SYMRND and the ldn legality constants (3, 11) SHALL come from the shared fixed_point/macros include.
REQ-035 One sub-module, fft_src_rnd, SHALL implement the combinational round/saturate of one rail and be instantiated twice.

Verification
REQ-036 ldn=3, start, then 8 consecutive samples 1..8 -> block_sync_o and stage_sync_o one pulse each, 8 data_val_o each one cycle after its input, then IDLE.
REQ-037 ldn=4 with start_i=1 on the sample 15 cycle -> new SYNC the next cycle, second block_sync_o, no idle cycle between blocks.
REQ-038 in_val_i in IDLE, start in RUN, and ldn=12 start -> err_o=1 in each case with no data emitted; clr_err_i -> err_o=0.
REQ-039 IN_WIDTH=`MAN_WIDTH+2, inputs +6 and -6 -> outputs +2 and -2, data_exp_o=2; input max positive -> clamped with FFT_SRC_SAT_EN, wrapped without.
REQ-040 rst_sys_n asserted after sample 5 of an ldn=3 block -> outputs 0 immediately; after release, a fresh start gives a clean 8-sample block.
